dtcore32_id_ex_stage: RTL and testbench

ID/EX pipeline stage directly downstream of the register file read ports. It captures the decoded instruction and the two register-file read operands. It resolves RAW hazards by forwarding from the MEM and WB stages, and detects load-use hazards. On a load-use hazard it requests an ID stall and injects a bubble into EX. It also maintains a saturating bubble counter for performance monitoring.

---
 rtl/dtcore32_id_ex_stage.sv | 122 ++++++++++++
 tb/tb_dtcore32_id_ex_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtcore32_id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding,
// load-use hazard detection and a saturating bubble counter.
module dtcore32_id_ex_stage #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [31:0]       id_pc_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic              id_reg_wr_en_i,
  input  logic              id_is_load_i,
  input  logic [31:0]       id_imm_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [31:0]       id_rs1_data_i,
  input  logic [31:0]       id_rs2_data_i,
  input  logic              mem_valid_i,
  input  logic              mem_reg_wr_en_i,
  input  logic [4:0]        mem_rd_i,
  input  logic [31:0]       mem_result_i,
  input  logic              wb_valid_i,
  input  logic              wb_reg_wr_en_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [31:0]       wb_result_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic [31:0]       ex_pc_o,
  output logic [31:0]       ex_rs1_data_o,
  output logic [31:0]       ex_rs2_data_o,
  output logic [4:0]        ex_rd_o,
  output logic              ex_reg_wr_en_o,
  output logic              ex_is_load_o,
  output logic [31:0]       ex_imm_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              load_use_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic        mem_wr;
  logic        wb_wr;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;
  logic        hit1;
  logic        hit2;

  assign mem_wr = mem_valid_i & mem_reg_wr_en_i & (mem_rd_i != 5'd0);
  assign wb_wr  = wb_valid_i & wb_reg_wr_en_i & (wb_rd_i != 5'd0);

  // Operand 1 select: x0 is hardwired, MEM beats WB beats regfile
  always_comb begin
    rs1_fwd = id_rs1_data_i;
    if (id_rs1_i == 5'd0)
      rs1_fwd = 32'd0;
    else if (mem_wr && mem_rd_i == id_rs1_i)
      rs1_fwd = mem_result_i;
    else if (wb_wr && wb_rd_i == id_rs1_i)
      rs1_fwd = wb_result_i;
  end

  // Operand 2 select: same priority as operand 1
  always_comb begin
    rs2_fwd = id_rs2_data_i;
    if (id_rs2_i == 5'd0)
      rs2_fwd = 32'd0;
    else if (mem_wr && mem_rd_i == id_rs2_i)
      rs2_fwd = mem_result_i;
    else if (wb_wr && wb_rd_i == id_rs2_i)
      rs2_fwd = wb_result_i;
  end

  assign hit1 = id_uses_rs1_i & (id_rs1_i == ex_rd_o);
  assign hit2 = id_uses_rs2_i & (id_rs2_i == ex_rd_o);

  // Load in EX feeding ID: hold IF/ID one cycle unless EX is frozen/killed
  always_comb begin
    load_use_stall_o = id_valid_i & ex_valid_o & ex_is_load_o &
                       (ex_rd_o != 5'd0) & (hit1 | hit2);
    if (stall_i || flush_i)
      load_use_stall_o = 1'b0;
  end

  // EX register: reset > flush > hold > bubble > capture
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || (!stall_i && load_use_stall_o)) begin
      ex_valid_o     <= 1'b0;
      ex_pc_o        <= '0;
      ex_rs1_data_o  <= '0;
      ex_rs2_data_o  <= '0;
      ex_rd_o        <= '0;
      ex_reg_wr_en_o <= 1'b0;
      ex_is_load_o   <= 1'b0;
      ex_imm_o       <= '0;
      ex_ctrl_o      <= '0;
    end else if (!stall_i) begin
      ex_valid_o     <= id_valid_i;
      ex_pc_o        <= id_pc_i;
      ex_rs1_data_o  <= rs1_fwd;
      ex_rs2_data_o  <= rs2_fwd;
      ex_rd_o        <= id_rd_i;
      ex_reg_wr_en_o <= id_reg_wr_en_i & id_valid_i;
      ex_is_load_o   <= id_is_load_i;
      ex_imm_o       <= id_imm_i;
      ex_ctrl_o      <= id_ctrl_i;
    end
  end

  // Saturating count of injected load-use bubbles
  always_ff @(posedge clk_i) begin
    if (rst_i)
      bubble_cnt_o <= '0;
    else if (!flush_i && !stall_i && load_use_stall_o &&
             bubble_cnt_o != {CNT_W{1'b1}})
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
  end

endmodule

// File: tb/tb_dtcore32_id_ex_stage.sv
// Directed testbench for dtcore32_id_ex_stage.
// Counter width 2 so saturation is reachable quickly.
module tb_dtcore32_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        id_reg_wr_en, id_is_load;
  logic [31:0] id_imm;
  logic [15:0] id_ctrl;
  logic [31:0] id_rs1_data, id_rs2_data;
  logic        mem_valid, mem_reg_wr_en;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_valid, wb_reg_wr_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        stall, flush;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_wr_en, ex_is_load;
  logic [31:0] ex_imm;
  logic [15:0] ex_ctrl;
  logic        lu_stall;
  logic [1:0]  bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  dtcore32_id_ex_stage #(.CTRL_W(16), .CNT_W(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(id_valid), .id_pc_i(id_pc),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
    .id_rd_i(id_rd), .id_reg_wr_en_i(id_reg_wr_en),
    .id_is_load_i(id_is_load), .id_imm_i(id_imm),
    .id_ctrl_i(id_ctrl),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data),
    .mem_valid_i(mem_valid), .mem_reg_wr_en_i(mem_reg_wr_en),
    .mem_rd_i(mem_rd), .mem_result_i(mem_result),
    .wb_valid_i(wb_valid), .wb_reg_wr_en_i(wb_reg_wr_en),
    .wb_rd_i(wb_rd), .wb_result_i(wb_result),
    .stall_i(stall), .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
    .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data),
    .ex_rd_o(ex_rd), .ex_reg_wr_en_o(ex_reg_wr_en),
    .ex_is_load_o(ex_is_load), .ex_imm_o(ex_imm),
    .ex_ctrl_o(ex_ctrl),
    .load_use_stall_o(lu_stall), .bubble_cnt_o(bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; id_pc = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_reg_wr_en = 0; id_is_load = 0;
    id_imm = 0; id_ctrl = 0;
    id_rs1_data = 0; id_rs2_data = 0;
    mem_valid = 0; mem_reg_wr_en = 0;
    mem_rd = 0; mem_result = 0;
    wb_valid = 0; wb_reg_wr_en = 0;
    wb_rd = 0; wb_result = 0;
    stall = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  // ID slot holds a load writing rd
  task automatic id_load(input logic [4:0] rd);
    idle();
    id_valid = 1; id_pc = 32'h400;
    id_rd = rd; id_reg_wr_en = 1; id_is_load = 1;
  endtask

  // ID slot holds an ALU op reading rs1/rs2
  task automatic id_alu(input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
    idle();
    id_valid = 1; id_pc = 32'h404;
    id_rs1 = r1; id_uses_rs1 = u1;
    id_rs2 = r2; id_uses_rs2 = u2;
    id_rd = 5'd7; id_reg_wr_en = 1;
  endtask

  task automatic test_reset();
    rst = 1; id_valid = 1; id_pc = 32'hFFFF_FFFF;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_reg_wr_en = 1; id_is_load = 1;
    id_imm = 32'h1234_5678; id_ctrl = 16'hFFFF;
    id_rs1_data = 32'h1; id_rs2_data = 32'h2;
    mem_valid = 1; mem_reg_wr_en = 1; mem_rd = 5'd1;
    mem_result = 32'h3;
    wb_valid = 1; wb_reg_wr_en = 1; wb_rd = 5'd2;
    wb_result = 32'h4;
    stall = 1; flush = 1;
    step();
    n_cmp++;
    if (ex_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_valid got %0h want 0", ex_valid); end
    n_cmp++;
    if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} !== 128'd0) begin n_err++;
      $display("FAIL reset_data got %h %h %h %h want 0",
               ex_pc, ex_rs1_data, ex_rs2_data, ex_imm); end
    n_cmp++;
    if ({ex_rd, ex_reg_wr_en, ex_is_load, ex_ctrl} !== 23'd0) begin n_err++;
      $display("FAIL reset_ctl got rd=%0d we=%0b ld=%0b ctrl=%h want 0",
               ex_rd, ex_reg_wr_en, ex_is_load, ex_ctrl); end
    n_cmp++;
    if (bubble_cnt !== 2'd0) begin n_err++;
      $display("FAIL reset_cnt got %0d want 0", bubble_cnt); end
    idle();
  endtask

  task automatic test_forward();
    id_alu(5'd1, 1, 5'd2, 1);
    id_rd = 5'd3; id_pc = 32'h100;
    id_imm = 32'h55; id_ctrl = 16'hA5A5;
    id_rs1_data = 32'h11; id_rs2_data = 32'h22;
    mem_valid = 1; mem_reg_wr_en = 1; mem_rd = 5'd1; mem_result = 32'hAA;
    wb_valid = 1; wb_reg_wr_en = 1; wb_rd = 5'd1; wb_result = 32'hBB;
    step();
    n_cmp++;
    if (ex_rs1_data !== 32'hAA) begin n_err++;
      $display("FAIL fwd_mem got %h want 000000aa", ex_rs1_data); end
    n_cmp++;
    if (ex_rs2_data !== 32'h22) begin n_err++;
      $display("FAIL fwd_none got %h want 00000022", ex_rs2_data); end
    n_cmp++;
    if ({ex_valid, ex_reg_wr_en, ex_rd, ex_pc, ex_imm, ex_ctrl}
        !== {1'b1, 1'b1, 5'd3, 32'h100, 32'h55, 16'hA5A5}) begin n_err++;
      $display("FAIL capture got v=%0b we=%0b rd=%0d pc=%h imm=%h ctrl=%h",
               ex_valid, ex_reg_wr_en, ex_rd, ex_pc, ex_imm, ex_ctrl); end
    mem_valid = 0;
    step();
    n_cmp++;
    if (ex_rs1_data !== 32'hBB) begin n_err++;
      $display("FAIL fwd_wb got %h want 000000bb", ex_rs1_data); end
    mem_valid = 1; mem_reg_wr_en = 0;
    wb_rd = 5'd2; wb_result = 32'h77; id_rs2_data = 32'h77;
    step();
    n_cmp++;
    if (ex_rs1_data !== 32'h11) begin n_err++;
      $display("FAIL fwd_mem_nowr got %h want 00000011", ex_rs1_data); end
    n_cmp++;
    if (ex_rs2_data !== 32'h77) begin n_err++;
      $display("FAIL fwd_wb_same got %h want 00000077", ex_rs2_data); end
    id_rs1 = 5'd0; id_rs1_data = 32'h5555;
    mem_reg_wr_en = 1; mem_rd = 5'd0; mem_result = 32'hCC;
    wb_rd = 5'd0; wb_result = 32'hDD;
    step();
    n_cmp++;
    if (ex_rs1_data !== 32'd0) begin n_err++;
      $display("FAIL fwd_x0 got %h want 0", ex_rs1_data); end
    idle();
    id_rd = 5'd9; id_reg_wr_en = 1;
    step();
    n_cmp++;
    if ({ex_valid, ex_reg_wr_en} !== 2'b00) begin n_err++;
      $display("FAIL invalid_we got v=%0b we=%0b want 0 0",
               ex_valid, ex_reg_wr_en); end
  endtask

  task automatic test_load_use();
    do_reset();
    id_load(5'd5);
    step();
    id_alu(5'd6, 1, 5'd5, 1);
    #1;
    n_cmp++;
    if (lu_stall !== 1'b1) begin n_err++;
      $display("FAIL lu_detect got %0b want 1", lu_stall); end
    step();
    n_cmp++;
    if ({ex_valid, ex_reg_wr_en, bubble_cnt} !== 4'b0001) begin n_err++;
      $display("FAIL lu_bubble got v=%0b we=%0b cnt=%0d want 0 0 1",
               ex_valid, ex_reg_wr_en, bubble_cnt); end
    wb_valid = 1; wb_reg_wr_en = 1; wb_rd = 5'd5; wb_result = 32'h1234;
    id_rs2_data = 32'h1234;
    #1;
    n_cmp++;
    if (lu_stall !== 1'b0) begin n_err++;
      $display("FAIL lu_release got %0b want 0", lu_stall); end
    step();
    n_cmp++;
    if ({ex_valid, ex_rs2_data, bubble_cnt} !== {1'b1, 32'h1234, 2'd1})
    begin n_err++;
      $display("FAIL lu_after got v=%0b rs2=%h cnt=%0d want 1 1234 1",
               ex_valid, ex_rs2_data, bubble_cnt); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    id_load(5'd5);
    step();
    id_alu(5'd6, 1, 5'd5, 0);
    #1;
    n_cmp++;
    if (lu_stall !== 1'b0) begin n_err++;
      $display("FAIL nh_unused got %0b want 0", lu_stall); end
    id_load(5'd0);
    step();
    n_cmp++;
    if ({ex_valid, bubble_cnt} !== 3'b100) begin n_err++;
      $display("FAIL nh_capture got v=%0b cnt=%0d want 1 0",
               ex_valid, bubble_cnt); end
    id_alu(5'd0, 1, 5'd0, 1);
    #1;
    n_cmp++;
    if (lu_stall !== 1'b0) begin n_err++;
      $display("FAIL nh_rd0 got %0b want 0", lu_stall); end
    id_load(5'd5);
    step();
    id_alu(5'd5, 1, 5'd0, 0);
    stall = 1;
    #1;
    n_cmp++;
    if (lu_stall !== 1'b0) begin n_err++;
      $display("FAIL nh_masked got %0b want 0", lu_stall); end
    stall = 0;
    #1;
    n_cmp++;
    if (lu_stall !== 1'b1) begin n_err++;
      $display("FAIL nh_rs1_hit got %0b want 1", lu_stall); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    id_alu(5'd1, 1, 5'd2, 1);
    id_pc = 32'h200; id_imm = 32'h77; id_ctrl = 16'hBEEF;
    id_rs1_data = 32'h10; id_rs2_data = 32'h20;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc = 32'h300 + i; id_imm = i; id_ctrl = 16'(i);
      id_rs1_data = 32'h99; id_rd = 5'd12;
      step();
      n_cmp++;
      if ({ex_valid, ex_pc, ex_imm, ex_ctrl, ex_rs1_data, ex_rd}
          !== {1'b1, 32'h200, 32'h77, 16'hBEEF, 32'h10, 5'd7})
      begin n_err++;
        $display("FAIL hold%0d got v=%0b pc=%h imm=%h ctrl=%h rs1=%h rd=%0d",
                 i, ex_valid, ex_pc, ex_imm, ex_ctrl, ex_rs1_data, ex_rd); end
    end
    flush = 1;
    step();
    n_cmp++;
    if ({ex_valid, ex_reg_wr_en} !== 2'b00) begin n_err++;
      $display("FAIL flush_stall got v=%0b we=%0b want 0 0",
               ex_valid, ex_reg_wr_en); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp [5];
    exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3;
    exp[3] = 2'd3; exp[4] = 2'd3;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      id_load(5'd5);
      step();
      id_alu(5'd5, 1, 5'd0, 0);
      step();
      n_cmp++;
      if (bubble_cnt !== exp[i]) begin n_err++;
        $display("FAIL sat%0d got %0d want %0d", i, bubble_cnt, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    id_load(5'd5);
    step();
    id_alu(5'd5, 1, 5'd0, 0);
    step();
    id_load(5'd5);
    step();
    id_alu(5'd5, 1, 5'd0, 0);
    #1;
    n_cmp++;
    if (lu_stall !== 1'b1) begin n_err++;
      $display("FAIL rms_pre got %0b want 1", lu_stall); end
    rst = 1;
    step();
    rst = 0;
    #1;
    n_cmp++;
    if ({ex_valid, lu_stall, bubble_cnt} !== 4'b0000) begin n_err++;
      $display("FAIL rms_post got v=%0b st=%0b cnt=%0d want 0 0 0",
               ex_valid, lu_stall, bubble_cnt); end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_forward();
    test_load_use();
    test_no_hazard();
    test_stall_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
